rgb_led_arbiter: RTL

Shares the single on-board RGB LED between four requesters (status sources, switch handlers, debug paths). Each requester asks for the LED with a 3-bit colour. A round-robin arbiter grants the LED to one requester for a fixed hold time, then returns to arbitration. A global PWM brightness is applied to the active-low LED_R/LED_G/LED_B pins. It sits between the requesting logic and the top-level LED pins and replaces direct counter-to-pin drives.

---
 rtl/rgb_led_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED between four requesters.
// A granted colour is held for HOLD_CYCLES, then dimmed by a global PWM onto active-low pins.
module rgb_led_arbiter #(
  parameter int unsigned HOLD_CYCLES = 12000000,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req,
  input  logic [11:0]         color,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [3:0]          grant,
  output logic [3:0]          done,
  output logic                LED_R,
  output logic                LED_G,
  output logic                LED_B
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [2:0]          color_q, color_d;
  logic [3:0]          grant_q, grant_d;
  logic [3:0]          done_q, done_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [2:0]          led_q, led_d;

  logic       found;
  logic [1:0] pick;
  logic [1:0] cand;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    color_d = color_q;
    grant_d = grant_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StShow;
          last_d  = pick;
          hold_d  = '0;
          color_d = color[3*pick +: 3];
          grant_d = 4'b0001 << pick;
        end
      end
      StShow: begin
        // Withdrawal wins over completion and never produces a done pulse.
        if (!req[last_q]) begin
          state_d = StGap;
          grant_d = '0;
        end else if (hold_q == HoldLast) begin
          state_d = StGap;
          grant_d = '0;
          done_d  = 4'b0001 << last_q;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    led_d = 3'b111;
    if (state_q == StShow && pwm_cnt_q < brightness) begin
      led_d = ~color_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 2'd3;
      hold_q    <= '0;
      color_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      pwm_cnt_q <= '0;
      led_q     <= 3'b111;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      color_q   <= color_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      led_q     <= led_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign LED_R = led_q[0];
  assign LED_G = led_q[1];
  assign LED_B = led_q[2];

endmodule
